// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle CPU: sequences IF/ID/EXE/MEM/WB and drives datapath strobes,
// mux selects and alu_op, with a bounded wait on the memory handshake.
module multicycle_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic       ext_sign,
  output logic [3:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    C_ADD, C_SUB, C_AND, C_OR, C_SLT, C_SLL,
    C_ADDI, C_ORI, C_LW, C_SW, C_BEQ, C_J, C_BAD
  } cls_e;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       ext_sign;
    logic [3:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
    logic       bus_err;
  } ctl_t;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  function automatic cls_e classify(input logic [5:0] o, input logic [5:0] f);
    cls_e c;
    c = C_BAD;
    case (o)
      6'b000000: begin
        case (f)
          6'b100000: c = C_ADD;
          6'b100010: c = C_SUB;
          6'b100100: c = C_AND;
          6'b100101: c = C_OR;
          6'b101010: c = C_SLT;
          6'b000000: c = C_SLL;
          default:   c = C_BAD;
        endcase
      end
      6'b001000: c = C_ADDI;
      6'b001101: c = C_ORI;
      6'b100011: c = C_LW;
      6'b101011: c = C_SW;
      6'b000100: c = C_BEQ;
      6'b000010: c = C_J;
      default:   c = C_BAD;
    endcase
    return c;
  endfunction

  function automatic logic is_rtype(input cls_e c);
    return (c == C_ADD) || (c == C_SUB) || (c == C_AND) ||
           (c == C_OR)  || (c == C_SLT) || (c == C_SLL);
  endfunction

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [5:0]       funct_q, funct_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  cls_e id_cls;
  cls_e ex_cls;
  logic mem_phase;
  logic stalled;
  logic timeout_hit;
  ctl_t ctl;

  assign id_cls    = classify(op, funct);
  assign ex_cls    = classify(op_q, funct_q);
  assign mem_phase = (state_q == S_IF) || (state_q == S_MEM);
  assign stalled   = mem_phase && !mem_ready;
  // mem_ready on the limit cycle still completes the access, so only a stalled cycle can time out
  assign timeout_hit = (TIMEOUT > 0) && stalled && (wait_cnt_q == CNT_LIMIT);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    funct_d = funct_q;
    ctl     = '0;

    case (state_q)
      S_IF: begin
        ctl.mem_read = 1'b1;
        if (mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          ctl.pc_src   = 2'd0;
          state_d      = S_ID;
        end else if (timeout_hit) begin
          ctl.bus_err = 1'b1;
        end
      end
      S_ID: begin
        op_d    = op;
        funct_d = funct;
        case (id_cls)
          C_J: begin
            ctl.pc_write = 1'b1;
            ctl.pc_src   = 2'd2;
            state_d      = S_IF;
          end
          C_BAD: begin
            ctl.illegal = 1'b1;
            state_d     = S_IF;
          end
          default: state_d = S_EXE;
        endcase
      end
      S_EXE: begin
        ctl.alu_src_a = (ex_cls == C_SLL);
        state_d       = S_WB;
        case (ex_cls)
          C_ADD:  ctl.alu_op = ALU_ADD;
          C_SUB:  ctl.alu_op = ALU_SUB;
          C_AND:  ctl.alu_op = ALU_AND;
          C_OR:   ctl.alu_op = ALU_OR;
          C_SLT:  ctl.alu_op = ALU_SLT;
          C_SLL:  ctl.alu_op = ALU_SLL;
          C_ADDI: begin
            ctl.alu_src_b = 1'b1;
            ctl.ext_sign  = 1'b1;
            ctl.alu_op    = ALU_ADD;
          end
          C_ORI: begin
            ctl.alu_src_b = 1'b1;
            ctl.alu_op    = ALU_OR;
          end
          C_LW, C_SW: begin
            ctl.alu_src_b = 1'b1;
            ctl.ext_sign  = 1'b1;
            ctl.alu_op    = ALU_ADD;
            state_d       = S_MEM;
          end
          C_BEQ: begin
            ctl.alu_op   = ALU_SUB;
            ctl.pc_write = zero;
            ctl.pc_src   = 2'd1;
            state_d      = S_IF;
          end
          default: state_d = S_IF;
        endcase
      end
      S_MEM: begin
        ctl.mem_read  = (ex_cls == C_LW);
        ctl.mem_write = (ex_cls == C_SW);
        if (mem_ready) begin
          state_d = (ex_cls == C_LW) ? S_WB : S_IF;
        end else if (timeout_hit) begin
          ctl.bus_err = 1'b1;
          state_d     = S_IF;
        end
      end
      S_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = is_rtype(ex_cls);
        ctl.mem_to_reg = (ex_cls == C_LW);
        state_d        = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  // Counter runs only while an access is stalled; any completion, timeout or state change clears it
  always_comb begin
    wait_cnt_d = '0;
    if (stalled && !timeout_hit) begin
      wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IF;
      op_q       <= '0;
      funct_q    <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      funct_q    <= funct_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Reset must silence the datapath immediately, even though IF would otherwise request a fetch
  assign {pc_write, pc_src, ir_write, mem_read, mem_write, alu_src_a, alu_src_b, ext_sign,
          alu_op, reg_write, reg_dst, mem_to_reg, illegal, bus_err} = rst_n ? ctl : '0;
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: builds an expected per-cycle trace from each instruction's phase list
// (fetch, decode, execute, memory, write-back) and replays it with random waits against the DUT.
module tb_multicycle_ctrl;

  localparam int TIMEOUT = 15;

  localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_OR = 3, K_SLT = 4, K_SLL = 5;
  localparam int K_ADDI = 6, K_ORI = 7, K_LW = 8, K_SW = 9, K_BEQ = 10, K_J = 11, K_BAD = 12;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       ext_sign;
    logic [3:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
    logic       bus_err;
  } ctl_t;

  typedef struct {
    logic       ready;
    logic       zero;
    logic [5:0] op;
    logic [5:0] funct;
    logic [2:0] st;
    ctl_t       ctl;
  } cyc_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, mem_read, mem_write, alu_src_a, alu_src_b, ext_sign;
  logic       reg_write, reg_dst, mem_to_reg, illegal, bus_err;
  logic [1:0] pc_src;
  logic [3:0] alu_op;
  logic [2:0] state_o;
  ctl_t       got;

  int checks = 0;
  int failures = 0;
  cyc_t trace[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_sign(ext_sign),
    .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal(illegal), .bus_err(bus_err), .state_o(state_o)
  );

  assign got = {pc_write, pc_src, ir_write, mem_read, mem_write, alu_src_a, alu_src_b, ext_sign,
                alu_op, reg_write, reg_dst, mem_to_reg, illegal, bus_err};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00) return f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00};
    return o inside {6'h08, 6'h0d, 6'h23, 6'h2b, 6'h04, 6'h02};
  endfunction

  task automatic encode(input int k, output logic [5:0] o, output logic [5:0] f);
    o = 6'h00;
    f = 6'($urandom);
    case (k)
      K_ADD:  f = 6'h20;
      K_SUB:  f = 6'h22;
      K_AND:  f = 6'h24;
      K_OR:   f = 6'h25;
      K_SLT:  f = 6'h2a;
      K_SLL:  f = 6'h00;
      K_ADDI: o = 6'h08;
      K_ORI:  o = 6'h0d;
      K_LW:   o = 6'h23;
      K_SW:   o = 6'h2b;
      K_BEQ:  o = 6'h04;
      K_J:    o = 6'h02;
      default: begin
        o = ($urandom_range(0, 1) == 0) ? 6'h00 : 6'($urandom);
        while (is_legal(o, f)) f = 6'($urandom);
      end
    endcase
  endtask

  task automatic push(input logic rdy, input logic z, input logic [5:0] o, input logic [5:0] f,
                      input logic [2:0] st, input ctl_t c);
    cyc_t r;
    r.ready = rdy; r.zero = z; r.op = o; r.funct = f; r.st = st; r.ctl = c;
    trace.push_back(r);
  endtask

  // Outside ID the decode inputs are don't-care, so they carry noise to prove latching
  task automatic push_noise(input logic rdy, input logic [2:0] st, input ctl_t c);
    push(rdy, 1'($urandom), 6'($urandom), 6'($urandom), st, c);
  endtask

  function automatic int pick_wait();
    int r = $urandom_range(0, 99);
    if (r < 65) return 0;
    if (r < 88) return $urandom_range(1, 4);
    if (r < 94) return TIMEOUT;
    return TIMEOUT + 1;
  endfunction

  // One memory access with w stalled cycles; beyond TIMEOUT stalls it is abandoned with bus_err
  task automatic access(input logic [2:0] st, input bit wr, input int force_w, output bit ok);
    int   w;
    ctl_t c;
    w = (force_w >= 0) ? force_w : pick_wait();
    c = '0;
    if (wr) c.mem_write = 1'b1;
    else c.mem_read = 1'b1;
    for (int i = 0; i < w && i < TIMEOUT; i++) push_noise(1'b0, st, c);
    if (w > TIMEOUT) begin
      c.bus_err = 1'b1;
      push_noise(1'b0, st, c);
      ok = 1'b0;
    end else begin
      if (st == 3'd0) begin
        c.ir_write = 1'b1;
        c.pc_write = 1'b1;
      end
      push_noise(1'b1, st, c);
      ok = 1'b1;
    end
  endtask

  task automatic instr(input int k, input int w_if, input int w_mem);
    bit         ok;
    logic       z;
    logic [5:0] o, f;
    ctl_t       c;
    encode(k, o, f);
    access(3'd0, 1'b0, w_if, ok);
    if (!ok) return;
    c = '0;
    if (k == K_J) begin c.pc_write = 1'b1; c.pc_src = 2'd2; end
    if (k == K_BAD) c.illegal = 1'b1;
    push(1'($urandom), 1'($urandom), o, f, 3'd1, c);
    if (k == K_J || k == K_BAD) return;
    c = '0;
    z = 1'($urandom);
    case (k)
      K_ADD: c.alu_op = 4'd0;
      K_SUB: c.alu_op = 4'd1;
      K_AND: c.alu_op = 4'd2;
      K_OR:  c.alu_op = 4'd3;
      K_SLT: c.alu_op = 4'd4;
      K_SLL: begin c.alu_op = 4'd5; c.alu_src_a = 1'b1; end
      K_ADDI, K_LW, K_SW: begin c.alu_src_b = 1'b1; c.ext_sign = 1'b1; c.alu_op = 4'd0; end
      K_ORI: begin c.alu_src_b = 1'b1; c.alu_op = 4'd3; end
      K_BEQ: begin c.alu_op = 4'd1; c.pc_write = z; c.pc_src = 2'd1; end
      default: ;
    endcase
    push(1'($urandom), z, 6'($urandom), 6'($urandom), 3'd2, c);
    if (k == K_BEQ) return;
    if (k == K_LW || k == K_SW) begin
      access(3'd3, k == K_SW, w_mem, ok);
      if (!ok || k == K_SW) return;
    end
    c = '0;
    c.reg_write  = 1'b1;
    c.reg_dst    = (k <= K_SLL);
    c.mem_to_reg = (k == K_LW);
    push_noise(1'($urandom), 3'd4, c);
  endtask

  // Called at a falling edge; replays n records (all when n < 0), ending on a falling edge
  task automatic run_trace(input int n);
    cyc_t r;
    int   done = 0;
    while (trace.size() > 0 && (n < 0 || done < n)) begin
      r = trace.pop_front();
      op = r.op; funct = r.funct; zero = r.zero; mem_ready = r.ready;
      #1;
      chk("state", 32'(state_o), 32'(r.st));
      chk("ctl", 32'(got), 32'(r.ctl));
      done++;
      @(negedge clk);
    end
  endtask

  initial begin
    ctl_t c;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_ctl", 32'(got), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    instr(K_ADD, 0, 0);
    instr(K_SLL, 0, 0);
    instr(K_LW, 0, 3);
    instr(K_BEQ, 0, 0);
    instr(K_J, 0, 0);
    instr(K_BAD, 0, 0);
    instr(K_ADD, TIMEOUT + 1, 0);
    instr(K_LW, TIMEOUT, TIMEOUT);
    instr(K_SW, 2, TIMEOUT + 1);
    instr(K_ORI, 0, 0);
    run_trace(-1);

    repeat (300) instr($urandom_range(0, 12), -1, -1);
    run_trace(-1);

    // Asynchronous reset in the middle of an EXE cycle abandons the instruction
    instr(K_ADD, 0, 0);
    run_trace(2);
    op = 6'h3f; funct = 6'h3f; zero = 1'b0; mem_ready = 1'b1;
    #1;
    chk("exe_state", 32'(state_o), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("async_state", 32'(state_o), 32'd0);
    chk("async_ctl", 32'(got), 32'd0);
    trace.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    c = '0;
    c.mem_read = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1;
    chk("post_rst_ctl", 32'(got), 32'(c));
    chk("post_rst_state", 32'(state_o), 32'd0);
    @(negedge clk);
    #1;
    chk("post_rst_id", 32'(state_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
